// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: default datapath width and the data-memory arbiter state type.
package cpu_pkg;

  localparam int ARB_WIDTH = 8;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_EXT_BURST = 2'd1,
    ARB_COOLDOWN  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; clear and reset take priority over increment.
module arb_sat_counter #(
  parameter int          W   = 8,
  parameter int unsigned MAX = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // NOTE: registered state is written with non-blocking assignments only, so every
  // always_ff reading cnt sees the pre-edge value regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != W'(MAX))) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU and one external burst requester; CPU has priority.
// Optional `define DMEM_ARBITER_STATS_EN adds stall_cnt / burst_cnt statistics outputs.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int WIDTH        = ARB_WIDTH,
  parameter int MAX_BURST    = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic             cpu_stall,
  input  logic             ext_req,
  input  logic             ext_we,
  input  logic [WIDTH-1:0] ext_addr,
  input  logic [WIDTH-1:0] ext_wdata,
  input  logic             ext_last,
  output logic             ext_gnt,
  output logic             mem_en,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_d_in
`ifdef DMEM_ARBITER_STATS_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [7:0]       burst_cnt
`endif
);

  arb_state_e state;
  arb_state_e next_state;
  logic [7:0] wait_cnt;
  logic [7:0] beat_cnt;
  logic       enter_burst;
  logic       exit_burst;
  logic       in_burst;

  assign in_burst = (state == ARB_EXT_BURST);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned
    // (which would infer a latch).
    next_state  = state;
    enter_burst = 1'b0;
    exit_burst  = 1'b0;
    mem_addr    = cpu_addr;
    mem_d_in    = cpu_wdata;
    mem_en      = cpu_req & cpu_we;
    ext_gnt     = 1'b0;
    cpu_stall   = 1'b0;

    unique case (state)
      ARB_IDLE: begin
        if (ext_req && (!cpu_req || (wait_cnt == 8'(STARVE_LIMIT)))) begin
          next_state  = ARB_EXT_BURST;
          enter_burst = 1'b1;
        end
      end
      ARB_EXT_BURST: begin
        mem_addr  = ext_addr;
        mem_d_in  = ext_wdata;
        mem_en    = ext_req & ext_we;
        ext_gnt   = ext_req;
        cpu_stall = cpu_req;
        // A dropped request, a last beat or the burst cap all end the tenure.
        if (!ext_req || ext_last || (beat_cnt == 8'(MAX_BURST - 1))) begin
          next_state = ARB_COOLDOWN;
          exit_burst = 1'b1;
        end
      end
      ARB_COOLDOWN: begin
        next_state = ARB_IDLE;
      end
      default: begin
        next_state = ARB_IDLE;
      end
    endcase

    // Nothing may write or be granted while reset is asserted, whatever the old state was.
    if (rst) begin
      mem_en    = 1'b0;
      ext_gnt   = 1'b0;
      cpu_stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Starvation counter runs only while the CPU holds memory and the requester is blocked.
  arb_sat_counter #(
    .W   (8),
    .MAX (STARVE_LIMIT)
  ) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (enter_burst | in_burst | ~ext_req),
    .inc (ext_req & cpu_req),
    .cnt (wait_cnt)
  );

  arb_sat_counter #(
    .W   (8),
    .MAX (MAX_BURST - 1)
  ) u_beat_cnt (
    .clk (clk),
    .rst (rst),
    .clr (exit_burst | ~in_burst),
    .inc (ext_gnt),
    .cnt (beat_cnt)
  );

`ifdef DMEM_ARBITER_STATS_EN
  arb_sat_counter #(
    .W   (16),
    .MAX (65535)
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (cpu_stall),
    .cnt (stall_cnt)
  );

  arb_sat_counter #(
    .W   (8),
    .MAX (255)
  ) u_burst_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (enter_burst & ~rst),
    .cnt (burst_cnt)
  );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: tenure-level reference model plus directed scenarios.
module tb_dmem_arbiter;
  localparam int WIDTH        = 8;
  localparam int MAX_BURST    = 8;
  localparam int STARVE_LIMIT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cpu_req, cpu_we;
  logic [WIDTH-1:0] cpu_addr, cpu_wdata;
  logic             cpu_stall;
  logic             ext_req, ext_we, ext_last;
  logic [WIDTH-1:0] ext_addr, ext_wdata;
  logic             ext_gnt, mem_en;
  logic [WIDTH-1:0] mem_addr, mem_d_in;
`ifdef DMEM_ARBITER_STATS_EN
  logic [15:0]      stall_cnt;
  logic [7:0]       burst_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int gnt_at[16];

  always #5 clk = ~clk;

  dmem_arbiter #(
    .WIDTH        (WIDTH),
    .MAX_BURST    (MAX_BURST),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_stall (cpu_stall),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_last  (ext_last),
    .ext_gnt   (ext_gnt),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_d_in  (mem_d_in)
`ifdef DMEM_ARBITER_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .burst_cnt (burst_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: who owns memory this tenure ----------------
  bit m_ext_owner;    // external requester holds a tenure
  bit m_cooldown;     // the mandatory CPU cycle right after a tenure
  int m_beats;        // beats granted in the current tenure
  int m_blocked;      // consecutive cycles the requester lost to the CPU
  int m_stalls;
  int m_bursts;

  function automatic bit exp_stall();
    return !rst && m_ext_owner && cpu_req;
  endfunction

  always @(posedge clk) begin
    bit grant_now;
    if (rst) begin
      m_ext_owner = 0; m_cooldown = 0; m_beats = 0; m_blocked = 0;
      m_stalls = 0; m_bursts = 0;
    end else begin
      if (exp_stall() && m_stalls < 65535) m_stalls++;
      if (m_ext_owner) begin
        m_blocked = 0;
        if (!ext_req) begin
          m_ext_owner = 0; m_cooldown = 1; m_beats = 0;
        end else begin
          m_beats++;
          if (ext_last || m_beats == MAX_BURST) begin
            m_ext_owner = 0; m_cooldown = 1; m_beats = 0;
          end
        end
      end else begin
        grant_now  = !m_cooldown && ext_req && (!cpu_req || m_blocked >= STARVE_LIMIT);
        m_cooldown = 0;
        if (grant_now) begin
          m_ext_owner = 1; m_blocked = 0;
          if (m_bursts < 255) m_bursts++;
        end else if (!ext_req) begin
          m_blocked = 0;
        end else if (cpu_req && m_blocked < STARVE_LIMIT) begin
          m_blocked++;
        end
      end
    end
  end

  // Single compare process, sampling mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_gnt", {31'd0, ext_gnt}, 32'd0);
      check("rst_stall", {31'd0, cpu_stall}, 32'd0);
      check("rst_en", {31'd0, mem_en}, 32'd0);
    end else if (m_ext_owner) begin
      check("gnt", {31'd0, ext_gnt}, {31'd0, ext_req});
      check("stall", {31'd0, cpu_stall}, {31'd0, cpu_req});
      check("en", {31'd0, mem_en}, {31'd0, ext_req & ext_we});
      check("addr", {24'd0, mem_addr}, {24'd0, ext_addr});
      check("d_in", {24'd0, mem_d_in}, {24'd0, ext_wdata});
    end else begin
      check("gnt", {31'd0, ext_gnt}, 32'd0);
      check("stall", {31'd0, cpu_stall}, 32'd0);
      check("en", {31'd0, mem_en}, {31'd0, cpu_req & cpu_we});
      check("addr", {24'd0, mem_addr}, {24'd0, cpu_addr});
      check("d_in", {24'd0, mem_d_in}, {24'd0, cpu_wdata});
    end
`ifdef DMEM_ARBITER_STATS_EN
    check("stall_cnt", {16'd0, stall_cnt}, 32'(m_stalls));
    check("burst_cnt", {24'd0, burst_cnt}, 32'(m_bursts));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one burst of n beats; gnt_at[k] records the cycle index of grant k.
  task automatic ext_burst(input int n, input bit use_last, input logic creq, output int ng);
    int beat = 0;
    ng = 0;
    for (int k = 0; k < 16; k++) gnt_at[k] = -1;
    for (int c = 0; c < 40 && beat < n; c++) begin
      tick();
      cpu_req   = creq;
      cpu_we    = creq;
      cpu_addr  = 8'h30;
      cpu_wdata = 8'h3C;
      ext_req   = 1'b1;
      ext_we    = 1'b1;
      ext_addr  = 8'h20 + 8'(beat);
      ext_wdata = 8'hC0 + 8'(beat);
      ext_last  = use_last && (beat == n - 1);
      #1;
      if (ext_gnt) begin
        if (ng < 16) gnt_at[ng] = c;
        ng++;
        beat++;
      end
    end
    check("burst_budget", 32'(beat), 32'(n));
    tick();
    ext_req  = 1'b0;
    ext_last = 1'b0;
  endtask

  initial begin
    int ng;
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 8'h00; ext_wdata = 8'h00; ext_last = 1'b0;
    tick(); tick();

    // CPU write from IDLE
    tick();
    rst = 1'b0; ext_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h10; cpu_wdata = 8'hA5;
    #1;
    check("idle_en", {31'd0, mem_en}, 32'd1);
    check("idle_addr", {24'd0, mem_addr}, 32'h10);
    check("idle_d_in", {24'd0, mem_d_in}, 32'hA5);
    check("idle_stall", {31'd0, cpu_stall}, 32'd0);
    check("idle_gnt", {31'd0, ext_gnt}, 32'd0);

    // Three-beat burst with CPU quiet: first grant one cycle after the request
    ext_burst(3, 1'b1, 1'b0, ng);
    check("quiet_ngnt", 32'(ng), 32'd3);
    check("quiet_first", 32'(gnt_at[0]), 32'd1);
    check("quiet_last", 32'(gnt_at[2]), 32'd3);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h11; cpu_wdata = 8'h5A;
    #1;
    check("cool_gnt", {31'd0, ext_gnt}, 32'd0);
    check("cool_en", {31'd0, mem_en}, 32'd1);
    tick();

    // Starvation: request blocked STARVE_LIMIT cycles, transition cycle, then grant
    ext_burst(2, 1'b1, 1'b1, ng);
    check("starve_first", 32'(gnt_at[0]), 32'(STARVE_LIMIT + 1));
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();

    // Burst cap: 8 beats, cooldown, re-arbitrate, next tenure starts
    ext_burst(9, 1'b0, 1'b0, ng);
    check("cap_beat8", 32'(gnt_at[7]), 32'd8);
    check("cap_beat9", 32'(gnt_at[8]), 32'd11);
    tick();

    // Reset in the middle of a burst
    ext_burst(2, 1'b0, 1'b0, ng);
    rst = 1'b1; ext_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
    #1;
    check("midrst_gnt", {31'd0, ext_gnt}, 32'd0);
    check("midrst_en", {31'd0, mem_en}, 32'd0);
    tick();
    rst = 1'b0; cpu_addr = 8'h44; cpu_wdata = 8'h99;
    #1;
    check("postrst_gnt", {31'd0, ext_gnt}, 32'd0);
    check("postrst_addr", {24'd0, mem_addr}, 32'h44);
    check("postrst_en", {31'd0, mem_en}, 32'd1);
    ext_burst(9, 1'b0, 1'b0, ng);
    check("postrst_beat8", 32'(gnt_at[7]), 32'd8);
    tick();

    // Request drops after two beats while CPU is busy
    ext_burst(2, 1'b0, 1'b1, ng);
    cpu_req = 1'b1;
    #1;
    check("drop_stall", {31'd0, cpu_stall}, 32'd1);
    check("drop_gnt", {31'd0, ext_gnt}, 32'd0);
    tick();
    #1;
    check("drop_cool_stall", {31'd0, cpu_stall}, 32'd0);
`ifdef DMEM_ARBITER_STATS_EN
    // Since reset: cap run 9 beats over 2 tenures, drop run 1 tenure with 3 stall cycles
    check("stats_bursts", {24'd0, burst_cnt}, 32'd3);
    check("stats_stalls", {16'd0, stall_cnt}, 32'd3);
`endif
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the CPU datapath and one external requester (loader/debug DMA port).
- Sits between the CPU's data-memory address mux / write-enable and data_mem.
- CPU has priority. The external requester wins by starvation timeout and then owns memory for a bounded burst.
- While the CPU is locked out, cpu_stall freezes the CPU; top level gates pc ld/increment, acc, reg_f and flag enables with it.

Parameters:
- WIDTH, 8, data and address width (matches CPU WIDTH)
- MAX_BURST, 8, max external beats per grant (2..255)
- STARVE_LIMIT, 4, consecutive blocked ext_req cycles before a forced external grant (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU accesses data memory this cycle (write, or read via in_b path)
- cpu_we  in  1  CPU write strobe (qualifies cpu_req)
- cpu_addr  in  WIDTH  CPU address
- cpu_wdata  in  WIDTH  CPU write data (acc)
- cpu_stall  out  1  CPU must hold state this cycle
- ext_req  in  1  external beat request; held until granted
- ext_we  in  1  external write strobe
- ext_addr  in  WIDTH  external address
- ext_wdata  in  WIDTH  external write data
- ext_last  in  1  final beat of the external burst
- ext_gnt  out  1  external beat accepted this cycle
- mem_en  out  1  data_mem write enable
- mem_addr  out  WIDTH  data_mem address
- mem_d_in  out  WIDTH  data_mem write data

Behaviour:
- States: IDLE, EXT_BURST, COOLDOWN. Encoded registered; all outputs are combinational from state and inputs.
- Reset (rst high at an edge): state=IDLE, wait_cnt=0, beat_cnt=0. During reset cycles: ext_gnt=0, cpu_stall=0, mem_en=0. rst mid-burst aborts the burst immediately; no partial-beat write occurs after the reset edge.
- IDLE:
  - CPU owns memory: mem_addr=cpu_addr, mem_d_in=cpu_wdata, mem_en=cpu_req&cpu_we. ext_gnt=0, cpu_stall=0.
  - wait_cnt increments (saturating) when ext_req&cpu_req; clears when ext_req=0.
  - Go to EXT_BURST when ext_req & (!cpu_req | wait_cnt==STARVE_LIMIT). wait_cnt clears on that transition.
  - Latency: first external beat is one cycle after the transition condition.
- EXT_BURST:
  - External owns memory: mem_addr=ext_addr, mem_d_in=ext_wdata, mem_en=ext_req&ext_we, ext_gnt=ext_req, cpu_stall=cpu_req.
  - beat_cnt increments on each ext_gnt.
  - Go to COOLDOWN when any of: (a) ext_gnt&ext_last; (b) ext_gnt and beat_cnt==MAX_BURST-1; (c) ext_req=0. Reads on the ext side take data_mem output combinationally in the granted cycle.
  - beat_cnt clears on exit.
- COOLDOWN:
  - Exactly one cycle, CPU owned as in IDLE, ext_gnt=0, so the CPU always gets at least one cycle between bursts. Then go to IDLE.
  - wait_cnt counts here too.
- Simultaneous cpu_req and ext_req in IDLE with wait_cnt<STARVE_LIMIT: CPU served, ext waits.
- ext_last with ext_req=0 is ignored.
- MAX_BURST boundary: beat MAX_BURST is never granted in the same tenure; the requester re-arbitrates.
- No combinational path from ext_* to cpu_stall except through state.

Optional Feature:
- Macro: DMEM_ARBITER_STATS_EN.
- Defined: adds outputs stall_cnt[15:0] (cycles with cpu_stall=1) and burst_cnt[7:0] (EXT_BURST entries). Both are saturating and cleared by rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg: state enum ARB_IDLE/ARB_EXT_BURST/ARB_COOLDOWN, default WIDTH.
- Natural sub-module: arb_sat_counter (parameterised saturating counter with clear/inc), instanced for wait_cnt, beat_cnt and the stats counters.

Test Plan:
- Reset then idle: cpu_req=1, cpu_we=1, addr=0x10, wdata=0xA5, ext_req=0 → mem_en=1, mem_addr=0x10, mem_d_in=0xA5, cpu_stall=0, ext_gnt=0.
- Ext with CPU quiet: ext_req=1, 3 beats at addr 0x20..0x22 with ext_last on the 3rd → ext_gnt high for 3 cycles starting 1 cycle after the request; then COOLDOWN 1 cycle, then IDLE.
- Starvation, STARVE_LIMIT=4: cpu_req=1 and ext_req=1 continuously → CPU served; EXT_BURST entered after wait_cnt reaches 4; cpu_stall=1 throughout the burst.
- Burst cap, MAX_BURST=8: ext_req held, ext_last never asserted → exactly 8 ext_gnt pulses, 1 COOLDOWN cycle, then re-grant if CPU idle.
- rst asserted at beat 2 of a burst → next cycle state=IDLE, ext_gnt=0, mem_en follows CPU only; beat_cnt=0 on the next grant.
- ext_req drops mid-burst after 2 beats → COOLDOWN next cycle; with DMEM_ARBITER_STATS_EN, burst_cnt increments by 1 and stall_cnt equals the observed stall cycles.
